// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART for the minisoc data bus.
//
// Optional receiver: define UART_RX_EN to build the RX synchroniser, the
// deserialiser and the RX STATUS bits. Without it, uart_rxd is ignored,
// STATUS[5:3] and DATA reads return 0 and CLEAR writes do nothing.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   uart_req          one-cycle access request (decoder already matched)
//   uart_write        1 = write, 0 = read
//   uart_wstrb        byte strobes
//   uart_addr         byte address, only [3:2] decoded
//   uart_wdata        write data
//   uart_ready        request accepted (always, same cycle)
//   uart_rvalid       read data valid, one cycle after the request
//   uart_rdata        registered read data, 0 when uart_rvalid = 0
//   uart_txd          serial output, idles high
//   uart_rxd          asynchronous serial input
//
// Bus handshake: a request is a single-cycle pulse on uart_req; it is always
// accepted in that cycle (uart_ready = uart_req). A read returns data with
// uart_rvalid high for exactly one cycle in the following cycle.
//
// Register map by addr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 CLEAR.
module uart #(
   parameter int          AW           = 16,
   parameter int          DW           = 32,
   parameter int          TXFIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET    = 16'd433
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            uart_req,
   input  logic            uart_write,
   input  logic [DW/8-1:0] uart_wstrb,
   input  logic [AW-1:0]   uart_addr,
   input  logic [DW-1:0]   uart_wdata,
   output logic            uart_ready,
   output logic            uart_rvalid,
   output logic [DW-1:0]   uart_rdata,
   output logic            uart_txd,
   input  logic            uart_rxd
);

   localparam int PW = $clog2(TXFIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic [1:0]  reg_sel;
   logic        wr_en, rd_en, push_req, push, pop;
   logic        fifo_empty, fifo_full;
   logic [PW:0] wr_ptr, rd_ptr;
   logic [7:0]  fifo_mem [TXFIFO_DEPTH];
   logic [15:0] div;
   logic [DW-1:0] rd_word;

   tx_state_t   tx_state;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bitn;
   logic [7:0]  tx_shift;

   logic [7:0]  rx_data;
   logic        rx_valid, rx_overrun, rx_frame_err;

   assign uart_ready = uart_req;
   assign reg_sel    = uart_addr[3:2];
   assign wr_en      = uart_req & uart_write;
   assign rd_en      = uart_req & ~uart_write;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   // The serialiser pops either from IDLE or at the end of a stop bit, the
   // latter giving back-to-back frames with no idle gap.
   assign pop      = ~fifo_empty & ((tx_state == TX_IDLE) |
                                    ((tx_state == TX_STOP) & (tx_cnt == 16'd0)));
   assign push_req = wr_en & (reg_sel == 2'd0) & uart_wstrb[0];
   // A push while full is only taken if a pop frees a slot in the same cycle.
   assign push     = push_req & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= uart_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // TX serialiser. The bit timer loads div at every bit start, so a DIV
   // write only affects the next bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bitn  <= '0;
         tx_shift <= '0;
         uart_txd <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  tx_state <= TX_START;
                  tx_shift <= fifo_mem[rd_ptr[PW-1:0]];
                  tx_cnt   <= div;
                  uart_txd <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt == 16'd0) begin
                  tx_state <= TX_DATA;
                  tx_cnt   <= div;
                  tx_bitn  <= '0;
                  uart_txd <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == 16'd0) begin
                  tx_cnt <= div;
                  if (tx_bitn == 3'd7) begin
                     tx_state <= TX_STOP;
                     uart_txd <= 1'b1;
                  end else begin
                     tx_bitn  <= tx_bitn + 3'd1;
                     tx_shift <= tx_shift >> 1;
                     uart_txd <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            default: begin // TX_STOP
               if (tx_cnt == 16'd0) begin
                  if (!fifo_empty) begin
                     tx_state <= TX_START;
                     tx_shift <= fifo_mem[rd_ptr[PW-1:0]];
                     tx_cnt   <= div;
                     uart_txd <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         2'd0:    rd_word[7:0] = rx_valid ? rx_data : 8'h00;
         2'd1:    rd_word[5:0] = {rx_frame_err, rx_overrun, rx_valid,
                                  (~fifo_empty | (tx_state != TX_IDLE)),
                                  fifo_empty, fifo_full};
         2'd2:    rd_word[15:0] = div;
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         uart_rvalid <= 1'b0;
         uart_rdata  <= '0;
         div         <= DIV_RESET;
      end else begin
         uart_rvalid <= rd_en;
         uart_rdata  <= rd_en ? rd_word : '0;
         if (wr_en && (reg_sel == 2'd2) && (uart_wstrb[1:0] == 2'b11))
            div <= uart_wdata[15:0];
      end
   end

`ifdef UART_RX_EN
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state;
   logic [1:0]  rx_sync;
   logic        rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bitn;
   logic [7:0]  rx_shift;
   logic        data_rd, clr_wr;
   logic        unused_bits;

   assign data_rd = rd_en & (reg_sel == 2'd0);
   assign clr_wr  = wr_en & (reg_sel == 2'd3) & uart_wstrb[0];
   assign unused_bits = ^{uart_addr[AW-1:4], uart_addr[1:0],
                          uart_wstrb[DW/8-1:2], uart_wdata[DW-1:16]};

   // Clears and the read-clear of rx_valid come first so that a flag or a
   // byte arriving in the same cycle wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync      <= 2'b11;
         rx_prev      <= 1'b1;
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bitn      <= '0;
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], uart_rxd};
         rx_prev <= rx_sync[1];
         if (data_rd) rx_valid <= 1'b0;
         if (clr_wr && uart_wdata[4]) rx_overrun   <= 1'b0;
         if (clr_wr && uart_wdata[5]) rx_frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync[1]) begin
                  rx_state <= RX_START;
                  rx_cnt   <= div >> 1;
               end
            end
            RX_START: begin
               if (rx_cnt == 16'd0) begin
                  rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                  rx_cnt   <= div;
                  rx_bitn  <= '0;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == 16'd0) begin
                  rx_shift <= {rx_sync[1], rx_shift[7:1]};
                  rx_cnt   <= div;
                  rx_bitn  <= rx_bitn + 3'd1;
                  if (rx_bitn == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            default: begin // RX_STOP
               if (rx_cnt == 16'd0) begin
                  rx_state <= RX_IDLE;
                  if (!rx_sync[1]) begin
                     rx_frame_err <= 1'b1;
                  end else if (!rx_valid || data_rd) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_overrun <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
         endcase
      end
   end
`else
   logic unused_bits;

   assign rx_data      = 8'h00;
   assign rx_valid     = 1'b0;
   assign rx_overrun   = 1'b0;
   assign rx_frame_err = 1'b0;
   assign unused_bits  = ^{uart_rxd, uart_addr[AW-1:4], uart_addr[1:0],
                           uart_wstrb[DW/8-1:2], uart_wdata[DW-1:16]};
`endif

endmodule
